// File: rtl/bcd_down_counter.sv
// Multi-digit BCD countdown timer: load a BCD value, decrement once every
// TICK_DIV clocks while running, stop at zero with a one-cycle done pulse.
module bcd_down_counter #(
  parameter int DIGITS   = 2,
  parameter int TICK_DIV = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  start,
  input  logic                  pause,
  output logic [4*DIGITS-1:0]   count,
  output logic                  running,
  output logic                  done,
  output logic                  err
);
  localparam int W  = 4*DIGITS;
  localparam int PW = $clog2(TICK_DIV) + 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;

  state_t          r_state, w_state_nxt;
  logic [W-1:0]    r_count, w_dec;
  logic [PW-1:0]   r_pre;
  logic            r_running, r_done, r_err;
  logic            w_running_nxt, w_done_nxt;
  logic [DIGITS-1:0] w_borrow, w_nib_ok;
  logic            w_load_ok, w_tick, w_zero, w_cnt_zero;

  // Per-digit borrow ripple; a digit only moves when everything below it is 0.
  assign w_borrow[0] = 1'b1;
  for (genvar d = 0; d < DIGITS; d++) begin : g_dig
    logic [3:0] w_dig;
    assign w_dig = r_count[4*d +: 4];
    assign w_dec[4*d +: 4] = !w_borrow[d] ? w_dig :
                             (w_dig == 4'd0) ? 4'd9 : w_dig - 4'd1;
    assign w_nib_ok[d] = (load_val[4*d +: 4] <= 4'd9);
    if (d < DIGITS-1) begin : g_brw
      assign w_borrow[d+1] = w_borrow[d] && (w_dig == 4'd0);
    end
  end

  assign w_load_ok  = &w_nib_ok;
  assign w_zero     = (w_dec == '0);
  assign w_cnt_zero = (r_count == '0);
  assign w_tick     = (r_state == S_RUN) && !load && !pause && (r_pre == PMAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (load) begin
      if (w_load_ok) w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (!pause && start && !w_cnt_zero) w_state_nxt = S_RUN;
        S_RUN:   if (pause) w_state_nxt = S_PAUSE;
                 else if (w_tick && w_zero) w_state_nxt = S_IDLE;
        S_PAUSE: if (!pause && start) w_state_nxt = S_RUN;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_running_nxt = (w_state_nxt == S_RUN);
    w_done_nxt    = w_tick && w_zero;
  end

  // Prescaler holds in PAUSE so a resume keeps the partial tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count   <= '0;
      r_pre     <= '0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_running <= w_running_nxt;
      r_done    <= w_done_nxt;
      if (load) begin
        r_pre <= '0;
        r_err <= !w_load_ok;
        if (w_load_ok) r_count <= load_val;
      end else begin
        if (w_tick) r_count <= w_dec;
        case (r_state)
          S_IDLE:  r_pre <= '0;
          S_RUN:   if (!pause) r_pre <= (r_pre == PMAX) ? '0 : r_pre + PW'(1);
          default: r_pre <= r_pre;
        endcase
      end
    end
  end

  assign count   = r_count;
  assign running = r_running;
  assign done    = r_done;
  assign err     = r_err;
endmodule

// File: tb/tb_bcd_down_counter.sv
// Directed bench for bcd_down_counter: three instances (2 digits/div 1,
// 2 digits/div 3, 3 digits/div 1) sharing clock, reset and controls.
module tb_bcd_down_counter;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load = 1'b0, start = 1'b0, pause = 1'b0;
  logic [7:0]  val8 = '0;
  logic [11:0] val12 = '0;
  logic [7:0]  a_cnt, b_cnt;
  logic [11:0] c_cnt;
  logic        a_run, a_done, a_err, b_run, b_done, b_err, c_run, c_done, c_err;
  int ncmp = 0, nfail = 0;

  always #5 clk = ~clk;

  bcd_down_counter #(.DIGITS(2), .TICK_DIV(1)) u_a (.clk(clk), .reset(reset), .load(load),
    .load_val(val8), .start(start), .pause(pause), .count(a_cnt), .running(a_run),
    .done(a_done), .err(a_err));
  bcd_down_counter #(.DIGITS(2), .TICK_DIV(3)) u_b (.clk(clk), .reset(reset), .load(load),
    .load_val(val8), .start(start), .pause(pause), .count(b_cnt), .running(b_run),
    .done(b_done), .err(b_err));
  bcd_down_counter #(.DIGITS(3), .TICK_DIV(1)) u_c (.clk(clk), .reset(reset), .load(load),
    .load_val(val12), .start(start), .pause(pause), .count(c_cnt), .running(c_run),
    .done(c_done), .err(c_err));

  function automatic logic [7:0] bcd8(input int n);
    return 8'(((n / 10) << 4) | (n % 10));
  endfunction

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic ld8(input logic [7:0] v);
    val8 = v; load = 1'b1; cyc(); load = 1'b0;
  endtask

  task automatic go();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic test_reset();
    #10; reset = 1'b1; cyc();
    ncmp++; if (a_cnt !== 8'h00 || a_run !== 1'b0 || a_done !== 1'b0 || a_err !== 1'b0) begin
      nfail++; $display("FAIL reset_a cnt=%h run=%b done=%b err=%b want 00/0/0/0", a_cnt, a_run, a_done, a_err); end
    ncmp++; if (c_cnt !== 12'h000 || c_run !== 1'b0 || b_cnt !== 8'h00 || b_run !== 1'b0) begin
      nfail++; $display("FAIL reset_bc b=%h c=%h want 00/000", b_cnt, c_cnt); end
  endtask

  task automatic test_basic();
    ld8(8'h12);
    ncmp++; if (a_cnt !== 8'h12 || a_run !== 1'b0) begin
      nfail++; $display("FAIL basic_load cnt=%h run=%b want 12/0", a_cnt, a_run); end
    go();
    ncmp++; if (a_cnt !== 8'h12 || a_run !== 1'b1) begin
      nfail++; $display("FAIL basic_start cnt=%h run=%b want 12/1", a_cnt, a_run); end
    for (int i = 1; i <= 12; i++) begin
      cyc();
      ncmp++; if (a_cnt !== bcd8(12 - i) || a_done !== (i == 12) || a_run !== (i != 12)) begin
        nfail++; $display("FAIL basic_step%0d cnt=%h done=%b run=%b want %h/%b/%b",
          i, a_cnt, a_done, a_run, bcd8(12 - i), (i == 12), (i != 12)); end
    end
    cyc();
    ncmp++; if (a_done !== 1'b0 || a_cnt !== 8'h00) begin
      nfail++; $display("FAIL basic_done_pulse done=%b cnt=%h want 0/00", a_done, a_cnt); end
    go(); cyc();
    ncmp++; if (a_run !== 1'b0 || a_cnt !== 8'h00 || a_done !== 1'b0) begin
      nfail++; $display("FAIL basic_start_zero run=%b cnt=%h done=%b want 0/00/0", a_run, a_cnt, a_done); end
  endtask

  task automatic test_invalid();
    ld8(8'h12);
    ld8(8'h1A);
    ncmp++; if (a_cnt !== 8'h12 || a_err !== 1'b1) begin
      nfail++; $display("FAIL inval_load cnt=%h err=%b want 12/1", a_cnt, a_err); end
    cyc(); cyc();
    ncmp++; if (a_err !== 1'b1) begin
      nfail++; $display("FAIL inval_sticky err=%b want 1", a_err); end
    ld8(8'h05);
    ncmp++; if (a_cnt !== 8'h05 || a_err !== 1'b0) begin
      nfail++; $display("FAIL inval_clear cnt=%h err=%b want 05/0", a_cnt, a_err); end
  endtask

  task automatic test_pause();
    logic [7:0] exp;
    ld8(8'h04);
    go();
    ncmp++; if (b_cnt !== 8'h04 || b_run !== 1'b1) begin
      nfail++; $display("FAIL pause_start cnt=%h run=%b want 04/1", b_cnt, b_run); end
    cyc(); cyc();
    ncmp++; if (b_cnt !== 8'h04) begin
      nfail++; $display("FAIL pause_prescale cnt=%h want 04", b_cnt); end
    cyc();
    ncmp++; if (b_cnt !== 8'h03) begin
      nfail++; $display("FAIL pause_first_dec cnt=%h want 03", b_cnt); end
    cyc();
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      ncmp++; if (b_cnt !== 8'h03 || b_run !== 1'b0) begin
        nfail++; $display("FAIL pause_hold%0d cnt=%h run=%b want 03/0", i, b_cnt, b_run); end
    end
    pause = 1'b0;
    go();
    ncmp++; if (b_cnt !== 8'h03 || b_run !== 1'b1) begin
      nfail++; $display("FAIL pause_resume cnt=%h run=%b want 03/1", b_cnt, b_run); end
    // After resume: 03 for one more edge, 02 at +2, 01 at +5, 00 at +8
    for (int k = 1; k <= 9; k++) begin
      cyc();
      exp = (k < 2) ? 8'h03 : (k < 5) ? 8'h02 : (k < 8) ? 8'h01 : 8'h00;
      ncmp++; if (b_cnt !== exp || b_done !== (k == 8)) begin
        nfail++; $display("FAIL pause_run%0d cnt=%h done=%b want %h/%b", k, b_cnt, b_done, exp, (k == 8)); end
    end
  endtask

  task automatic test_borrow();
    val12 = 12'h100; load = 1'b1; cyc(); load = 1'b0;
    go();
    cyc();
    ncmp++; if (c_cnt !== 12'h099) begin
      nfail++; $display("FAIL borrow_100 cnt=%h want 099", c_cnt); end
    cyc();
    ncmp++; if (c_cnt !== 12'h098 || c_run !== 1'b1) begin
      nfail++; $display("FAIL borrow_098 cnt=%h run=%b want 098/1", c_cnt, c_run); end
    val12 = 12'h010; load = 1'b1; cyc(); load = 1'b0;
    ncmp++; if (c_cnt !== 12'h010 || c_run !== 1'b0 || c_done !== 1'b0) begin
      nfail++; $display("FAIL borrow_reload cnt=%h run=%b done=%b want 010/0/0", c_cnt, c_run, c_done); end
    go(); cyc();
    ncmp++; if (c_cnt !== 12'h009) begin
      nfail++; $display("FAIL borrow_010 cnt=%h want 009", c_cnt); end
  endtask

  task automatic test_reset_mid();
    ld8(8'h50);
    go(); cyc(); cyc();
    ld8(8'hFF);
    ncmp++; if (a_cnt !== 8'h48 || a_err !== 1'b1 || a_run !== 1'b1) begin
      nfail++; $display("FAIL rmid_badload cnt=%h err=%b run=%b want 48/1/1", a_cnt, a_err, a_run); end
    cyc();
    ncmp++; if (a_cnt !== 8'h47) begin
      nfail++; $display("FAIL rmid_run cnt=%h want 47", a_cnt); end
    #2; reset = 1'b0; #1;
    ncmp++; if (a_cnt !== 8'h00 || a_run !== 1'b0 || a_done !== 1'b0 || a_err !== 1'b0) begin
      nfail++; $display("FAIL rmid_async cnt=%h run=%b done=%b err=%b want 00/0/0/0", a_cnt, a_run, a_done, a_err); end
    #2; reset = 1'b1;
    cyc();
  endtask

  task automatic test_load_run();
    ld8(8'h50);
    go(); cyc(); cyc();
    ld8(8'h30);
    ncmp++; if (a_cnt !== 8'h30 || a_run !== 1'b0 || a_done !== 1'b0) begin
      nfail++; $display("FAIL lrun_abort cnt=%h run=%b done=%b want 30/0/0", a_cnt, a_run, a_done); end
    cyc(); cyc();
    ncmp++; if (a_cnt !== 8'h30 || a_done !== 1'b0) begin
      nfail++; $display("FAIL lrun_idle cnt=%h done=%b want 30/0", a_cnt, a_done); end
    go(); cyc();
    ncmp++; if (a_cnt !== 8'h29 || a_run !== 1'b1) begin
      nfail++; $display("FAIL lrun_restart cnt=%h run=%b want 29/1", a_cnt, a_run); end
    start = 1'b1; pause = 1'b1; cyc(); start = 1'b0; pause = 1'b0;
    ncmp++; if (a_cnt !== 8'h29 || a_run !== 1'b0) begin
      nfail++; $display("FAIL lrun_pausewins cnt=%h run=%b want 29/0", a_cnt, a_run); end
    cyc(); cyc();
    ncmp++; if (a_cnt !== 8'h29 || a_run !== 1'b0 || a_done !== 1'b0) begin
      nfail++; $display("FAIL lrun_paused cnt=%h run=%b done=%b want 29/0/0", a_cnt, a_run, a_done); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_invalid();
    test_pause();
    test_borrow();
    test_reset_mid();
    test_load_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
